fir_mac_param: RTL and testbench

//  Parametrised FIR filter; successor to the fixed 4-tap, 8-bit combinational FIR in this design.
//  One shared multiplier is time-multiplexed over TAPS cycles per sample.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_coef_bank.sv | 34 +++
 rtl/fir_mac_param.sv | 109 ++++++++++
 tb/tb_fir_mac_param.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR filter.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Clamp an unsigned value to the largest out_w-bit number.
    function automatic logic [63:0] sat(input logic [63:0] v, input int unsigned out_w);
        logic [63:0] max_v;
        max_v = (64'd1 << out_w) - 64'd1;
        return (v > max_v) ? max_v : v;
    endfunction

    function automatic int unsigned coef_default(input int unsigned k);
        return k + 1;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// Run-time programmable coefficient registers with a combinational read port.
module fir_coef_bank
    import fir_pkg::*;
#(
    parameter int unsigned COEF_W = 8,
    parameter int unsigned TAPS   = 4,
    localparam int unsigned IDX_W = $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [COEF_W-1:0] data,
    input  logic [IDX_W-1:0]  idx,
    output logic [COEF_W-1:0] rd_data
);

    logic [COEF_W-1:0] coef [TAPS];

    // Writes only land while the filter is idle, so a sample in flight never sees a change.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                coef[k] <= COEF_W'(coef_default(k));
            end
        end else if (we && en && (32'(addr) < TAPS)) begin
            coef[addr] <= data;
        end
    end

    assign rd_data = coef[idx];

endmodule

// File: rtl/fir_mac_param.sv
// Parametrised FIR: one shared multiplier stepped over TAPS cycles per sample,
// saturated and scaled output, valid/ready on both sides.
module fir_mac_param
    import fir_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned COEF_W    = 8,
    parameter int unsigned TAPS      = 4,
    parameter int unsigned OUT_SHIFT = 0,
    localparam int unsigned IDX_W    = $clog2(TAPS),
    localparam int unsigned ACC_W    = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              coef_we,
    input  logic [IDX_W-1:0]  coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic              busy
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;

    state_t             state;
    logic [DATA_W-1:0]  taps [TAPS];
    logic [ACC_W-1:0]   acc;
    logic [IDX_W-1:0]   idx;
    logic [COEF_W-1:0]  coef_rd;
    logic [PROD_W-1:0]  prod;
    logic [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   scaled;
    logic [DATA_W-1:0]  sat_val;
    logic               last;

    fir_coef_bank #(
        .COEF_W (COEF_W),
        .TAPS   (TAPS)
    ) u_coef_bank (
        .clk     (clk),
        .reset   (reset),
        .en      (state == IDLE),
        .we      (coef_we),
        .addr    (coef_addr),
        .data    (coef_data),
        .idx     (idx),
        .rd_data (coef_rd)
    );

    always_comb begin
        prod    = PROD_W'(taps[idx]) * PROD_W'(coef_rd);
        acc_sum = acc + ACC_W'(prod);
        scaled  = acc_sum >> OUT_SHIFT;
        sat_val = DATA_W'(sat(64'(scaled), DATA_W));
        last    = (idx == IDX_W'(TAPS - 1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                taps[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        taps[0] <= in_data;
                        for (int unsigned k = 1; k < TAPS; k++) begin
                            taps[k] <= taps[k-1];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc_sum;
                    idx <= idx + IDX_W'(1);
                    // The final product is folded in directly rather than waiting a cycle for acc.
                    if (last) begin
                        out_data  <= sat_val;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_fir_mac_param.sv
// Self-checking bench for fir_mac_param: vector table, directed corner cases, random vs. model.
module tb_fir_mac_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid, out_ready, coef_we;
    logic [7:0] in_data, coef_data;
    logic [1:0] coef_addr;
    logic       in_ready0, out_valid0, busy0;
    logic [7:0] out_data0;
    logic       in_ready1, out_valid1, busy1;
    logic [7:0] out_data1;

    logic       in_valid2, out_ready2, coef_we2;
    logic [7:0] in_data2, coef_data2;
    logic [1:0] coef_addr2;
    logic       in_ready2, out_valid2, busy2;
    logic [7:0] out_data2;

    fir_mac_param dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy0)
    );

    fir_mac_param #(.OUT_SHIFT(4)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data), .busy(busy1)
    );

    fir_mac_param #(.TAPS(3)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .coef_we(coef_we2), .coef_addr(coef_addr2), .coef_data(coef_data2), .busy(busy2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference model: the last four accepted samples (newest first) and the coefficient set.
    int hist[$];
    int coefm[4];

    function automatic void model_reset();
        hist.delete();
        for (int k = 0; k < 4; k++) coefm[k] = k + 1;
    endfunction

    function automatic void model_accept(input int d);
        hist.push_front(d);
        if (hist.size() > 4) void'(hist.pop_back());
    endfunction

    function automatic int model_out(input int sh);
        int y;
        y = 0;
        for (int k = 0; k < hist.size(); k++) y += hist[k] * coefm[k];
        y = y >> sh;
        return (y > 255) ? 255 : y;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
        in_valid2 = 1'b0; coef_we2 = 1'b0; out_ready2 = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (out_valid0) begin
                lat = n;
                break;
            end
        end
    endtask

    // One full transaction on dut0/dut1: accept, MAC, optional backpressure, handshake.
    task automatic run_sample(input int d, input int hold, input bit wr, input int wa, input int wd,
                              input bit mwr, output int g0, output int g1);
        int lat;
        @(negedge clk);
        check("in_ready_idle", {31'd0, in_ready0}, 1);
        in_valid = 1'b1; in_data = d[7:0];
        coef_we = wr; coef_addr = wa[1:0]; coef_data = wd[7:0];
        @(posedge clk); #1;
        in_valid = 1'b0; coef_we = 1'b0;
        if (wr) coefm[wa] = wd;
        model_accept(d);
        check("busy_after_accept", {30'd0, busy0, in_ready0}, 2);
        if (mwr) begin
            coef_we = 1'b1; coef_addr = 2'd3; coef_data = 8'd99;
        end
        wait_out(lat);
        coef_we = 1'b0;
        check("latency", lat, 4);
        g0 = int'(out_data0);
        g1 = int'(out_data1);
        if (hold > 0) begin
            out_ready = 1'b0;
            repeat (hold) begin
                @(posedge clk); #1;
                check("hold_stable", {22'd0, out_valid0, in_ready0, out_data0}, {22'd0, 1'b1, 1'b0, g0[7:0]});
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check("handshake", {29'd0, out_valid0, busy0, in_ready0}, 1);
    endtask

    task automatic run2(input int d, output int g);
        int lat;
        @(negedge clk);
        in_valid2 = 1'b1; in_data2 = d[7:0];
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (out_valid2) begin
                lat = n;
                break;
            end
        end
        check("latency_taps3", lat, 3);
        g = int'(out_data2);
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit rst;
        int d;
        int e0;
        int e1;
    } vec_t;

    vec_t tab[15];

    initial begin
        int g0, g1, g, lat;
        int exp_taps3[3];
        bit seen;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; coef_we = 1'b0;
        in_data = '0; coef_data = '0; coef_addr = '0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; coef_we2 = 1'b0;
        in_data2 = '0; coef_data2 = '0; coef_addr2 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        check("reset_state", {20'd0, out_valid0, busy0, in_ready0, out_data0, 1'b0}, {20'd0, 1'b0, 1'b0, 1'b1, 8'd0, 1'b0});

        // Impulse, step and saturation with default coefficients 1,2,3,4.
        tab[0]  = '{1, 1, 1, 0};     tab[1]  = '{0, 0, 2, 0};     tab[2]  = '{0, 0, 3, 0};
        tab[3]  = '{0, 0, 4, 0};     tab[4]  = '{0, 0, 0, 0};
        tab[5]  = '{1, 10, 10, 0};   tab[6]  = '{0, 10, 30, 1};   tab[7]  = '{0, 10, 60, 3};
        tab[8]  = '{0, 10, 100, 6};  tab[9]  = '{0, 10, 100, 6};
        tab[10] = '{1, 255, 255, 15};  tab[11] = '{0, 255, 255, 47}; tab[12] = '{0, 255, 255, 95};
        tab[13] = '{0, 255, 255, 159}; tab[14] = '{0, 255, 255, 159};
        for (int i = 0; i < 15; i++) begin
            if (tab[i].rst) apply_reset();
            run_sample(tab[i].d, 0, 1'b0, 0, 0, 1'b0, g0, g1);
            check("tab_shift0", g0, tab[i].e0);
            check("tab_shift4", g1, tab[i].e1);
        end

        // Backpressure with a second sample held on the input the whole time.
        apply_reset();
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'd7;
        @(posedge clk); #1;
        in_data = 8'd3;
        out_ready = 1'b0;
        model_accept(7);
        wait_out(lat);
        check("bp_latency", lat, 4);
        check("bp_data", {24'd0, out_data0}, 7);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_stall", {22'd0, out_valid0, in_ready0, out_data0}, {22'd0, 1'b1, 1'b0, 8'd7});
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release", {30'd0, out_valid0, in_ready0}, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_accept(3);
        check("bp_held_accept", {30'd0, busy0, in_ready0}, 2);
        wait_out(lat);
        check("bp_held_data", {24'd0, out_data0}, model_out(0));
        @(posedge clk); #1;
        check("bp_done", {31'd0, out_valid0}, 0);

        // Coefficient write in IDLE, then an ignored write during MAC.
        apply_reset();
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 2'd2; coef_data = 8'd0;
        @(posedge clk); #1;
        coef_we = 1'b0;
        coefm[2] = 0;
        for (int rep = 0; rep < 2; rep++) begin
            run_sample(1, 0, 1'b0, 0, 0, rep == 1, g0, g1); check("coef_imp0", g0, 1);
            run_sample(0, 0, 1'b0, 0, 0, 1'b0, g0, g1);     check("coef_imp1", g0, 2);
            run_sample(0, 0, 1'b0, 0, 0, 1'b0, g0, g1);     check("coef_imp2", g0, 0);
            run_sample(0, 0, 1'b0, 0, 0, 1'b0, g0, g1);     check("coef_imp3", g0, 4);
        end
        // Sample and coefficient write on the same edge: new coef0=5 applies to this sample.
        run_sample(2, 0, 1'b1, 0, 5, 1'b0, g0, g1);
        check("coef_same_edge", g0, 10);

        // Out-of-range coefficient address on a 3-tap instance.
        apply_reset();
        @(negedge clk);
        coef_we2 = 1'b1; coef_addr2 = 2'd3; coef_data2 = 8'd50;
        @(posedge clk); #1;
        coef_we2 = 1'b0;
        exp_taps3 = '{1, 2, 3};
        for (int i = 0; i < 3; i++) begin
            run2((i == 0) ? 1 : 0, g);
            check("taps3_imp", g, exp_taps3[i]);
        end

        // Reset in the middle of MAC discards the sample and restores defaults.
        apply_reset();
        @(negedge clk);
        coef_we = 1'b1; coef_addr = 2'd1; coef_data = 8'd0;
        @(posedge clk); #1;
        coef_we = 1'b0;
        coefm[1] = 0;
        run_sample(5, 0, 1'b0, 0, 0, 1'b0, g0, g1);
        check("pre_reset_out", g0, 5);
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("midmac_reset", {21'd0, out_valid0, busy0, out_data0, 1'b0}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        model_reset();
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid0) seen = 1'b1;
        end
        check("no_output_after_reset", {31'd0, seen}, 0);
        for (int i = 0; i < 4; i++) begin
            run_sample((i == 0) ? 1 : 0, 0, 1'b0, 0, 0, 1'b0, g0, g1);
            check("post_reset_imp", g0, i + 1);
        end

        // Random samples, coefficient writes and backpressure against the model.
        apply_reset();
        for (int i = 0; i < 40; i++) begin
            int d, hold, wa, wd;
            bit wr;
            d    = int'($urandom_range(0, 255));
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            wr   = ($urandom_range(0, 3) == 0);
            wa   = int'($urandom_range(0, 3));
            wd   = int'($urandom_range(0, 255));
            run_sample(d, hold, wr, wa, wd, 1'b0, g0, g1);
            check("rand_shift0", g0, model_out(0));
            check("rand_shift4", g1, model_out(4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not reach the summary in time");
        $fatal(1);
    end

endmodule
